// File: rtl/cpu_exec_sequencer.sv
// Multi-cycle execution sequencer for the bbtron CPU datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB so that the
// synchronous instruction and data RAMs get their full read latency. It
// gates the state-element strobes, waits on the enter button for IN,
// parks on HLT and supports single-step operation.
module cpu_exec_sequencer #(
  parameter int MEM_LAT = 1,   // RAM read latency in cycles, 1..15
  parameter int CNT_W   = 16   // retired-instruction counter width
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             enter_pulse,
  input  logic             cu_writeReg,
  input  logic             cu_writeEnable,
  input  logic             cu_readEnable,
  input  logic             cu_inSignal,
  input  logic             cu_hlt,
  input  logic             cu_showDisplay,
  output logic             ir_load,
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_we,
  output logic             mem_re,
  output logic             disp_load,
  output logic             waiting_input,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_WAIT_IN = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  // Index of the final cycle of a FETCH or MEM phase.
  localparam logic [3:0] LAST_CYC = 4'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wait_last;

  assign wait_last = (wait_cnt_q == LAST_CYC);

  // State, latency counter and retired counter registers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state selection and strobe decode. The counter falls back to zero
  // whenever it is not advancing, so every FETCH and MEM entry starts at 0.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    retired_d     = retired_q;
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    reg_we        = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    disp_load     = 1'b0;
    waiting_input = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || enter_pulse) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_last) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        if (cu_hlt)           state_d = S_HALT;
        else if (cu_inSignal) state_d = S_WAIT_IN;
        else                  state_d = S_EXEC;
      end
      S_WAIT_IN: begin
        waiting_input = 1'b1;
        if (enter_pulse) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cu_readEnable || cu_writeEnable) state_d = S_MEM;
        else                                 state_d = S_WB;
      end
      S_MEM: begin
        // Read enable is held for the whole access; the write fires once.
        mem_re = cu_readEnable;
        mem_we = cu_writeEnable && (wait_cnt_q == 4'd0);
        if (wait_last) state_d = S_WB;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_WB: begin
        reg_we    = cu_writeReg;
        pc_en     = 1'b1;
        disp_load = cu_showDisplay;
        retired_d = retired_q + 1'b1;
        state_d   = step_mode ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Self-checking bench for cpu_exec_sequencer. Two instances share stimulus:
// dut_a (MEM_LAT=1, CNT_W=4) and dut_b (MEM_LAT=2, CNT_W=16); each scenario
// targets one of them. Expected per-cycle outputs are built as a phase list
// from the instruction's flags.
module tb_cpu_exec_sequencer;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic start = 1'b0, step_mode = 1'b0, enter_pulse = 1'b0;
  logic cu_writeReg = 1'b0, cu_writeEnable = 1'b0, cu_readEnable = 1'b0;
  logic cu_inSignal = 1'b0, cu_hlt = 1'b0, cu_showDisplay = 1'b0;

  logic a_ir_load, a_pc_en, a_reg_we, a_mem_we, a_mem_re, a_disp_load, a_waiting_input, a_halted;
  logic [2:0] a_state;
  logic [3:0] a_retired;
  logic b_ir_load, b_pc_en, b_reg_we, b_mem_we, b_mem_re, b_disp_load, b_waiting_input, b_halted;
  logic [2:0] b_state;
  logic [15:0] b_retired;

  int checks = 0;
  int errors = 0;
  int ret_m[2];

  always #5 clock = ~clock;

  cpu_exec_sequencer #(.MEM_LAT(1), .CNT_W(4)) dut_a (
    .clock(clock), .n_reset(n_reset), .start(start), .step_mode(step_mode),
    .enter_pulse(enter_pulse), .cu_writeReg(cu_writeReg), .cu_writeEnable(cu_writeEnable),
    .cu_readEnable(cu_readEnable), .cu_inSignal(cu_inSignal), .cu_hlt(cu_hlt),
    .cu_showDisplay(cu_showDisplay), .ir_load(a_ir_load), .pc_en(a_pc_en),
    .reg_we(a_reg_we), .mem_we(a_mem_we), .mem_re(a_mem_re), .disp_load(a_disp_load),
    .waiting_input(a_waiting_input), .halted(a_halted), .state(a_state), .retired(a_retired)
  );

  cpu_exec_sequencer #(.MEM_LAT(2), .CNT_W(16)) dut_b (
    .clock(clock), .n_reset(n_reset), .start(start), .step_mode(step_mode),
    .enter_pulse(enter_pulse), .cu_writeReg(cu_writeReg), .cu_writeEnable(cu_writeEnable),
    .cu_readEnable(cu_readEnable), .cu_inSignal(cu_inSignal), .cu_hlt(cu_hlt),
    .cu_showDisplay(cu_showDisplay), .ir_load(b_ir_load), .pc_en(b_pc_en),
    .reg_we(b_reg_we), .mem_we(b_mem_we), .mem_re(b_mem_re), .disp_load(b_disp_load),
    .waiting_input(b_waiting_input), .halted(b_halted), .state(b_state), .retired(b_retired)
  );

  // Observation vector: {state, ir_load, pc_en, reg_we, mem_we, mem_re, disp_load, waiting_input, halted}
  function automatic logic [10:0] obs(input int sel);
    if (sel == 1)
      return {b_state, b_ir_load, b_pc_en, b_reg_we, b_mem_we, b_mem_re, b_disp_load, b_waiting_input, b_halted};
    return {a_state, a_ir_load, a_pc_en, a_reg_we, a_mem_we, a_mem_re, a_disp_load, a_waiting_input, a_halted};
  endfunction

  function automatic logic [15:0] ret_obs(input int sel);
    if (sel == 1) return b_retired;
    return 16'(a_retired);
  endfunction

  function automatic logic [15:0] ret_exp(input int sel);
    if (sel == 1) return 16'(ret_m[1] % 65536);
    return 16'(ret_m[0] % 16);
  endfunction

  // Flags byte order: ir_load, pc_en, reg_we, mem_we, mem_re, disp_load, waiting_input, halted
  function automatic logic [10:0] mk(input logic [2:0] st, input logic [7:0] f);
    return {st, f};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input string tag);
    n_reset = 1'b0;
    start = 1'b0; enter_pulse = 1'b0; step_mode = 1'b0;
    cu_writeReg = 1'b0; cu_writeEnable = 1'b0; cu_readEnable = 1'b0;
    cu_inSignal = 1'b0; cu_hlt = 1'b0; cu_showDisplay = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs(s) !== 11'd0 || ret_obs(s) !== 16'd0) begin
        errors++;
        $display("FAIL %s_reset dut%0d: got obs=%b retired=%0d want obs=0 retired=0", tag, s, obs(s), ret_obs(s));
      end
      ret_m[s] = 0;
    end
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  // Called with the selected DUT in its first FETCH cycle; uses the current
  // cu_* settings. Checks every cycle up to and including the exit from WB
  // (or arrival in HALT), then the follow-on state and the retired count.
  task automatic run_instr(input int sel, input int waitn, input bit fetch_enter, input string tag);
    logic [10:0] exp_q[$];
    bit          pulse_q[$];
    int          lat;
    logic [10:0] got;
    logic [2:0]  end_st;
    lat = (sel == 1) ? 2 : 1;
    for (int k = 0; k < lat; k++) begin
      exp_q.push_back(mk(3'd1, (k == lat - 1) ? 8'h80 : 8'h00));
      pulse_q.push_back(fetch_enter && k == 0);
    end
    exp_q.push_back(mk(3'd2, 8'h00)); pulse_q.push_back(1'b0);
    if (cu_hlt) begin
      exp_q.push_back(mk(3'd7, 8'h01)); pulse_q.push_back(1'b0);
    end else begin
      if (cu_inSignal) begin
        for (int k = 0; k < waitn; k++) begin
          exp_q.push_back(mk(3'd6, 8'h02));
          pulse_q.push_back(k == waitn - 1);
        end
      end
      exp_q.push_back(mk(3'd3, 8'h00)); pulse_q.push_back(1'b0);
      if (cu_readEnable || cu_writeEnable) begin
        for (int k = 0; k < lat; k++) begin
          exp_q.push_back(mk(3'd4, {3'b000, cu_writeEnable && k == 0, cu_readEnable, 3'b000}));
          pulse_q.push_back(1'b0);
        end
      end
      exp_q.push_back(mk(3'd5, {1'b0, 1'b1, cu_writeReg, 2'b00, cu_showDisplay, 2'b00}));
      pulse_q.push_back(1'b0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = obs(sel);
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle%0d dut%0d: got %b want %b", tag, i, sel, got, exp_q[i]);
      end
      enter_pulse = pulse_q[i];
      tick();
      enter_pulse = 1'b0;
    end
    if (!cu_hlt) ret_m[sel]++;
    end_st = cu_hlt ? 3'd7 : (step_mode ? 3'd0 : 3'd1);
    checks++;
    if (obs(sel) >> 8 !== 11'(end_st) || ret_obs(sel) !== ret_exp(sel)) begin
      errors++;
      $display("FAIL %s_end dut%0d: got state=%0d retired=%0d want state=%0d retired=%0d",
               tag, sel, obs(sel) >> 8, ret_obs(sel), end_st, ret_exp(sel));
    end
  endtask

  task automatic set_cu(input bit wr, input bit we, input bit re, input bit inn, input bit hlt, input bit disp);
    cu_writeReg = wr; cu_writeEnable = we; cu_readEnable = re;
    cu_inSignal = inn; cu_hlt = hlt; cu_showDisplay = disp;
  endtask

  task automatic test_alu();
    do_reset("alu");
    set_cu(1, 0, 0, 0, 0, 0);
    start = 1'b1; enter_pulse = 1'b1;   // both in one cycle: single transition
    tick();
    start = 1'b0; enter_pulse = 1'b0;
    run_instr(0, 0, 0, "alu_l1");
    run_instr(0, 0, 0, "alu_l1_b2b");
  endtask

  task automatic test_load_store();
    do_reset("ldst");
    set_cu(1, 0, 1, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    run_instr(1, 0, 0, "load_l2");
    set_cu(0, 1, 0, 0, 0, 0);
    run_instr(1, 0, 0, "store_l2");
    set_cu(1, 1, 1, 0, 0, 1);
    run_instr(1, 0, 0, "rw_both_l2");
  endtask

  task automatic test_reset_mid_mem();
    do_reset("midmem");
    set_cu(1, 0, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    run_instr(1, 0, 0, "pre_alu");
    set_cu(1, 0, 1, 0, 0, 0);
    repeat (4) tick();                   // FETCH x2, DECODE, EXEC
    checks++;
    if (b_state !== 3'd4 || b_mem_re !== 1'b1) begin
      errors++;
      $display("FAIL midmem_inmem: got state=%0d mem_re=%b want state=4 mem_re=1", b_state, b_mem_re);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if (obs(1) !== 11'd0 || b_retired !== 16'd0) begin
      errors++;
      $display("FAIL midmem_async: got obs=%b retired=%0d want obs=0 retired=0", obs(1), b_retired);
    end
    ret_m[0] = 0; ret_m[1] = 0;
    tick();
    n_reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (b_state !== 3'd1) begin
      errors++;
      $display("FAIL midmem_restart: got state=%0d want 1", b_state);
    end
    run_instr(1, 0, 0, "after_reset_load");
  endtask

  task automatic test_wait_in();
    do_reset("waitin");
    set_cu(1, 0, 0, 1, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    run_instr(0, 100, 1, "in_wait100");
    set_cu(0, 0, 0, 1, 0, 0);
    run_instr(0, 3, 0, "in_wait3");
  endtask

  task automatic test_halt();
    do_reset("halt");
    set_cu(1, 0, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    run_instr(0, 0, 0, "pre_halt");
    set_cu(0, 0, 0, 0, 1, 0);
    run_instr(0, 0, 0, "hlt");
    for (int c = 0; c < 50; c++) begin
      enter_pulse = (c == 20);
      checks++;
      if (a_state !== 3'd7 || a_halted !== 1'b1 || a_pc_en !== 1'b0 || a_reg_we !== 1'b0 || a_mem_we !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold c%0d: got state=%0d halted=%b pc_en=%b want state=7 halted=1 pc_en=0",
                 c, a_state, a_halted, a_pc_en);
      end
      tick();
      enter_pulse = 1'b0;
    end
    set_cu(1, 0, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (a_state !== 3'd1 || ret_obs(0) !== ret_exp(0)) begin
      errors++;
      $display("FAIL halt_resume: got state=%0d retired=%0d want state=1 retired=%0d", a_state, ret_obs(0), ret_exp(0));
    end
    run_instr(0, 0, 0, "post_halt");
  endtask

  task automatic test_step_wrap();
    do_reset("wrap");
    step_mode = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      set_cu(1'($urandom_range(0, 1)), 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      enter_pulse = 1'b1; tick(); enter_pulse = 1'b0;
      run_instr(0, 0, 0, $sformatf("step%0d", n));
      repeat (3) tick();               // must stay paused in IDLE
      checks++;
      if (a_state !== 3'd0) begin
        errors++;
        $display("FAIL step%0d_pause: got state=%0d want 0", n, a_state);
      end
    end
    checks++;
    if (a_retired !== 4'd0) begin
      errors++;
      $display("FAIL wrap_final: got retired=%0d want 0", a_retired);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_random(input int sel);
    bit inn;
    do_reset("rand");
    set_cu(0, 0, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      inn = ($urandom_range(0, 3) == 0);
      set_cu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             inn, 0, 1'($urandom_range(0, 1)));
      run_instr(sel, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), $sformatf("rand%0d_%0d", sel, n));
    end
  endtask

  initial begin
    test_alu();
    test_load_store();
    test_reset_mid_mem();
    test_wait_in();
    test_halt();
    test_step_wrap();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
